bus_sync_pipe: RTL

BUS_SYNC_PIPE -- requirements
Module: bus_sync_pipe

---
 rtl/bus_sync_pipe.sv | 135 +++++++++++++
 1 files changed

// File: rtl/bus_sync_pipe.sv
// rtl/bus_sync_pipe.sv - in-order command queue with single-outstanding master handshake and response timeout
module bus_sync_pipe #(
  parameter type cp_t    = logic [31:0],
  parameter type dp_t    = logic [31:0],
  parameter int  DEPTH   = 2,
  parameter int  TIMEOUT = 255,
  parameter dp_t ERRDATA = '1
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       cpvalids,
  input  cp_t                        cpdatas,
  output logic                       cpreadys,
  output logic                       dpvalids,
  output dp_t                        dpdatas,
  output logic                       dperrs,
  output logic                       ovfs,
  output logic [$clog2(DEPTH+1)-1:0] pending,
  output logic                       cpvalidm,
  output cp_t                        cpdatam,
  input  logic                       dpreadym,
  input  dp_t                        dpdatam
);

  localparam int CW   = $clog2(DEPTH + 1);
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_GAP} state_t;

  state_t          r_state;
  cp_t             r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [TW-1:0]   r_wait;
  logic            r_cpvalidm;
  cp_t             r_cpdatam;
  logic            r_dpvalids;
  dp_t             r_dpdatas;
  logic            r_dperrs;
  logic            r_ovfs;

  logic            w_rdy;
  logic            w_acc;
  logic            w_busy;
  logic            w_tmo;
  logic            w_pop;
  logic            w_have;
  cp_t             w_head;

  assign w_rdy  = (r_count < CW'(DEPTH));
  assign w_acc  = cpvalids & w_rdy;
  assign w_busy = (r_state == S_BUSY);
  assign w_tmo  = (TIMEOUT > 0) && w_busy && !dpreadym && (r_wait == TW'(TLIM));
  assign w_pop  = w_busy & (dpreadym | w_tmo);
  // An accept into an empty queue bypasses storage so the master sees it one cycle later.
  assign w_have = (r_count != '0) || w_acc;
  assign w_head = (r_count != '0) ? r_mem[r_rptr] : cpdatas;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_wait     <= '0;
      r_cpvalidm <= 1'b0;
      r_cpdatam  <= '0;
      r_dpvalids <= 1'b0;
      r_dpdatas  <= '0;
      r_dperrs   <= 1'b0;
      r_ovfs     <= 1'b0;
    end else begin
      if (cpvalids && !w_rdy) r_ovfs <= 1'b1;

      if (w_acc) begin
        r_mem[r_wptr] <= cpdatas;
        r_wptr        <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + PW'(1);
      end
      if (w_pop) r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + PW'(1);

      case ({w_acc, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      // Completion beats timeout when both land in the same BUSY cycle.
      r_dpvalids <= w_pop;
      if (w_pop) begin
        r_dpdatas <= dpreadym ? dpdatam : ERRDATA;
        r_dperrs  <= !dpreadym;
      end

      case (r_state)
        S_IDLE, S_GAP: begin
          if (w_have) begin
            r_state    <= S_BUSY;
            r_cpvalidm <= 1'b1;
            r_cpdatam  <= w_head;
            r_wait     <= '0;
          end else begin
            r_state    <= S_IDLE;
            r_cpvalidm <= 1'b0;
          end
        end
        S_BUSY: begin
          if (w_pop) begin
            r_state    <= S_GAP;
            r_cpvalidm <= 1'b0;
          end else if (TIMEOUT > 0) begin
            r_wait <= r_wait + TW'(1);
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_cpvalidm <= 1'b0;
        end
      endcase
    end
  end

  assign cpreadys = w_rdy;
  assign pending  = r_count;
  assign cpvalidm = r_cpvalidm;
  assign cpdatam  = r_cpdatam;
  assign dpvalids = r_dpvalids;
  assign dpdatas  = r_dpdatas;
  assign dperrs   = r_dperrs;
  assign ovfs     = r_ovfs;

endmodule
